// File: rtl/rtc_bram.sv
// rtc_bram: 32-bit seconds counter and 256x8 battery RAM behind a data/control register pair.
// Optional write-protect flag (command 0x35) is built in when RTC_BRAM_WRITE_PROTECT_EN is defined.
module rtc_bram #(
    parameter int unsigned TICKS_PER_SEC = 2500000,
    parameter int unsigned BUSY_CEN      = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       cen,
    input  logic       strobe,
    input  logic       rw,
    input  logic       addr,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BW = (BUSY_CEN > 1) ? $clog2(BUSY_CEN) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_CEN - 1);

    typedef enum logic [1:0] {IDLE, EXT, DATA} state_t;
    typedef enum logic [1:0] {SEL_SECS, SEL_BRAM, SEL_WP} sel_t;

    state_t        r_state, w_state_next;
    sel_t          r_sel, w_sel_next;
    logic [1:0]    r_sec_byte, w_sec_byte_next;
    logic [7:0]    r_bram_addr, w_bram_addr_next;
    logic [7:0]    r_data;
    logic          r_ctl_rd;
    logic          r_ctl_last;
    logic [3:0]    r_ctl_low;
    logic          r_busy;
    logic [BW-1:0] r_busy_cnt;
    logic          r_pend;
    logic [TW-1:0] r_tick_cnt;
    logic [31:0]   r_secs;
    logic          r_inc_defer;
    logic [7:0]    r_ram_q;
    logic [7:0]    r_mem [256];

    logic          w_wr_strobe;
    logic          w_start;
    logic          w_tick;
    logic          w_protect;
    logic [7:0]    w_rd_byte;
    logic          w_data_load;
    logic [7:0]    w_data_next;
    logic          w_secs_we;
    logic          w_bram_we;

    assign w_wr_strobe = strobe & ~rw & ~r_busy;
    assign w_start     = w_wr_strobe & addr & din[7];
    assign w_tick      = cen & (r_tick_cnt == TICK_LAST);

    assign dout = addr ? {r_busy, r_ctl_rd, r_ctl_last, 1'b0, r_ctl_low} : r_data;

`ifdef RTC_BRAM_WRITE_PROTECT_EN
    logic r_wp;
    logic w_wp_we;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_wp <= 1'b0;
        end else if (w_wp_we) begin
            r_wp <= r_data[7];
        end
    end

    assign w_protect = r_wp;
`else
    assign w_protect = 1'b0;
`endif

    always_comb begin
        w_rd_byte = 8'h00;
        case (r_sel)
            SEL_SECS: w_rd_byte = r_secs[{r_sec_byte, 3'b000} +: 8];
            SEL_BRAM: w_rd_byte = r_ram_q;
            default:  w_rd_byte = {w_protect, 7'b0000000};
        endcase
    end

    // A transfer is executed in the single cycle where r_pend is high.
    always_comb begin
        w_state_next     = r_state;
        w_sel_next       = r_sel;
        w_sec_byte_next  = r_sec_byte;
        w_bram_addr_next = r_bram_addr;
        w_data_load      = 1'b0;
        w_data_next      = r_data;
        w_secs_we        = 1'b0;
        w_bram_we        = 1'b0;
`ifdef RTC_BRAM_WRITE_PROTECT_EN
        w_wp_we          = 1'b0;
`endif
        if (r_pend) begin
            case (r_state)
                IDLE: begin
                    if (r_ctl_rd) begin
                        w_data_load = 1'b1;
                        w_data_next = 8'h00;
                    end else if (r_data[6:4] == 3'b000 && r_data[1:0] == 2'b01) begin
                        w_sel_next      = SEL_SECS;
                        w_sec_byte_next = r_data[3:2];
                        w_state_next    = DATA;
                    end else if (r_data[6:3] == 4'b0111) begin
                        w_sel_next       = SEL_BRAM;
                        w_bram_addr_next = {r_data[2:0], r_bram_addr[4:0]};
                        w_state_next     = EXT;
                    end
`ifdef RTC_BRAM_WRITE_PROTECT_EN
                    else if (r_data == 8'h35) begin
                        w_sel_next   = SEL_WP;
                        w_state_next = DATA;
                    end
`endif
                end
                EXT: begin
                    w_bram_addr_next = {r_bram_addr[7:5], r_data[6:2]};
                    w_state_next     = DATA;
                end
                DATA: begin
                    if (r_ctl_rd) begin
                        w_data_load = 1'b1;
                        w_data_next = w_rd_byte;
                    end else begin
                        case (r_sel)
                            SEL_SECS: w_secs_we = ~w_protect;
                            SEL_BRAM: w_bram_we = ~w_protect;
                            default: begin
`ifdef RTC_BRAM_WRITE_PROTECT_EN
                                w_wp_we = 1'b1;
`endif
                            end
                        endcase
                    end
                    w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
            if (r_ctl_last) begin
                w_state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sel       <= SEL_SECS;
            r_sec_byte  <= 2'd0;
            r_bram_addr <= 8'h00;
        end else begin
            r_state     <= w_state_next;
            r_sel       <= w_sel_next;
            r_sec_byte  <= w_sec_byte_next;
            r_bram_addr <= w_bram_addr_next;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_data      <= 8'h00;
            r_ctl_rd    <= 1'b0;
            r_ctl_last  <= 1'b0;
            r_ctl_low   <= 4'h0;
            r_busy      <= 1'b0;
            r_busy_cnt  <= '0;
            r_pend      <= 1'b0;
            r_tick_cnt  <= '0;
            r_secs      <= 32'h0;
            r_inc_defer <= 1'b0;
        end else begin
            r_pend <= w_start;
            if (w_wr_strobe && !addr) begin
                r_data <= din;
            end else if (w_data_load) begin
                r_data <= w_data_next;
            end
            if (w_wr_strobe && addr) begin
                r_ctl_rd   <= din[6];
                r_ctl_last <= din[5];
                r_ctl_low  <= din[3:0];
            end
            if (w_start) begin
                r_busy     <= 1'b1;
                r_busy_cnt <= '0;
            end else if (r_busy && cen) begin
                if (r_busy_cnt == BUSY_LAST) begin
                    r_busy <= 1'b0;
                end else begin
                    r_busy_cnt <= r_busy_cnt + BW'(1);
                end
            end
            if (cen) begin
                r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            end
            // A byte write wins over a coincident tick; the increment lands one cycle later.
            if (w_secs_we) begin
                r_secs[{r_sec_byte, 3'b000} +: 8] <= r_data;
                r_inc_defer <= w_tick | r_inc_defer;
            end else if (w_tick || r_inc_defer) begin
                r_secs      <= r_secs + 32'd1;
                r_inc_defer <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_bram_we) begin
            r_mem[r_bram_addr] <= r_data;
        end
        r_ram_q <= r_mem[r_bram_addr];
    end

endmodule

// File: tb/tb_rtc_bram.sv
// tb_rtc_bram: directed stimulus for rtc_bram with a transaction-level reference model,
// a per-cycle dout comparison and literal checkpoints.
module tb_rtc_bram;
    localparam int TPS = 50;
    localparam int BC  = 3;
    localparam int PH_IDLE = 0, PH_EXT = 1, PH_DATA = 2;
    localparam int T_SECS = 0, T_BRAM = 1, T_WP = 2;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       cen     = 1'b0;
    logic       strobe  = 1'b0;
    logic       rw      = 1'b1;
    logic       addr    = 1'b0;
    logic [7:0] din     = 8'h00;
    logic [7:0] dout;

    int n_vec = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    rtc_bram #(.TICKS_PER_SEC(TPS), .BUSY_CEN(BC)) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .cen    (cen),
        .strobe (strobe),
        .rw     (rw),
        .addr   (addr),
        .din    (din),
        .dout   (dout)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference model state
    logic [7:0]  m_data;
    bit          m_ctl_rd, m_ctl_last;
    logic [3:0]  m_ctl_low;
    int          m_busy_left;
    bit          m_pend;
    int          m_phase, m_target, m_byte, m_addr;
    logic [31:0] m_secs;
    int          m_cen_total;
    bit          m_defer;
    bit          m_wp;
    logic [7:0]  m_bram [256];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: dout=%02h expected %02h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_sys) begin
        if (checking) begin
            check("cycle", dout,
                  addr ? {m_busy_left != 0, m_ctl_rd, m_ctl_last, 1'b0, m_ctl_low} : m_data);
        end
    end

    task automatic model_reset();
        m_data = 8'h00; m_ctl_rd = 1'b0; m_ctl_last = 1'b0; m_ctl_low = 4'h0;
        m_busy_left = 0; m_pend = 1'b0; m_phase = PH_IDLE; m_target = T_SECS;
        m_byte = 0; m_addr = 0; m_secs = 32'h0; m_cen_total = 0; m_defer = 1'b0; m_wp = 1'b0;
    endtask

    task automatic model_transfer(output bit secs_wr);
        secs_wr = 1'b0;
        if (m_phase == PH_IDLE) begin
            if (m_ctl_rd) begin
                m_data = 8'h00;
            end else if (m_data[6:4] == 3'b000 && m_data[1:0] == 2'b01) begin
                m_target = T_SECS; m_byte = int'(m_data[3:2]); m_phase = PH_DATA;
            end else if (m_data[6:3] == 4'b0111) begin
                m_target = T_BRAM; m_addr = int'(m_data[2:0]) * 32 + m_addr % 32; m_phase = PH_EXT;
            end
`ifdef RTC_BRAM_WRITE_PROTECT_EN
            else if (m_data == 8'h35) begin
                m_target = T_WP; m_phase = PH_DATA;
            end
`endif
        end else if (m_phase == PH_EXT) begin
            m_addr  = (m_addr / 32) * 32 + int'(m_data[6:2]);
            m_phase = PH_DATA;
        end else begin
            if (m_ctl_rd) begin
                if (m_target == T_SECS)      m_data = 8'(m_secs >> (8 * m_byte));
                else if (m_target == T_BRAM) m_data = m_bram[m_addr];
                else                         m_data = {m_wp, 7'b0000000};
            end else if (m_target == T_WP) begin
                m_wp = m_data[7];
            end else if (!m_wp) begin
                if (m_target == T_SECS) begin
                    m_secs  = (m_secs & ~(32'hFF << (8 * m_byte))) | (32'(m_data) << (8 * m_byte));
                    secs_wr = 1'b1;
                end else begin
                    m_bram[m_addr] = m_data;
                end
            end
            m_phase = PH_IDLE;
        end
        if (m_ctl_last) m_phase = PH_IDLE;
    endtask

    task automatic model_edge();
        bit busy_before, pend_before, secs_wr;
        busy_before = (m_busy_left != 0);
        pend_before = m_pend;
        secs_wr     = 1'b0;
        m_pend      = 1'b0;
        if (pend_before) model_transfer(secs_wr);
        if (m_defer) begin
            m_secs  = m_secs + 32'd1;
            m_defer = 1'b0;
        end
        if (cen) begin
            m_cen_total++;
            if ((m_cen_total % TPS) == 0) begin
                if (secs_wr) m_defer = 1'b1;
                else         m_secs  = m_secs + 32'd1;
            end
            if (busy_before) m_busy_left--;
        end
        if (strobe && !rw && !busy_before) begin
            if (!addr) begin
                m_data = din;
            end else begin
                m_ctl_rd = din[6]; m_ctl_last = din[5]; m_ctl_low = din[3:0];
                if (din[7]) begin
                    m_busy_left = BC;
                    m_pend      = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic s, input logic r, input logic a, input logic [7:0] d, input logic c);
        strobe = s; rw = r; addr = a; din = d; cen = c;
        @(posedge clk_sys);
        model_edge();
        #2;
    endtask

    task automatic do_reset();
        strobe = 1'b0; rw = 1'b1; cen = 1'b0; reset = 1'b1;
        model_reset();
        @(posedge clk_sys);
        #2;
        reset = 1'b0;
    endtask

    task automatic lit(input string name, input logic a, input logic [7:0] exp);
        strobe = 1'b0; rw = 1'b1; addr = a; cen = 1'b0;
        #1 check(name, dout, exp);
        @(posedge clk_sys);
        model_edge();
        #2;
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, 1'b0, 1'b0, d, 1'b0);
    endtask

    task automatic idle_cen(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic xfer(input logic [7:0] ctl);
        step(1'b1, 1'b0, 1'b1, ctl, 1'b0);
        for (int i = 0; i < BC; i++) step(1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
        $display("xfer ctl=%02h data=%02h secs=%08h t=%0t", ctl, m_data, m_secs, $time);
    endtask

    task automatic read_secs(input logic [1:0] b);
        wr({4'b0000, b, 2'b01});
        xfer(8'h80);
        xfer(8'hC0);
    endtask

    task automatic write_secs(input logic [1:0] b, input logic [7:0] v);
        wr({4'b0000, b, 2'b01});
        xfer(8'h80);
        wr(v);
        xfer(8'h80);
    endtask

    task automatic bram_select(input logic [7:0] a);
        wr({5'b00111, a[7:5]});
        xfer(8'h80);
        wr({1'b0, a[4:0], 2'b00});
        xfer(8'h80);
    endtask

    task automatic bram_write(input logic [7:0] a, input logic [7:0] v);
        bram_select(a);
        wr(v);
        xfer(8'h80);
    endtask

    task automatic bram_read(input logic [7:0] a);
        bram_select(a);
        xfer(8'hC0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, expected finish before t=2000000");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) m_bram[i] = 8'h00;
        do_reset();
        checking = 1'b1;

        // Reset values, then two seconds of cen pulses
        lit("rst_ctl", 1'b1, 8'h00);
        lit("rst_data", 1'b0, 8'h00);
        idle_cen(2 * TPS);
        read_secs(2'd0);
        lit("secs_2", 1'b0, 8'h02);

        // Extended BRAM write of 0xA5, with writes attempted while busy
        wr(8'h3D);
        step(1'b1, 1'b0, 1'b1, 8'h80, 1'b0);
        lit("busy_set", 1'b1, 8'h80);
        step(1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'hE0, 1'b0);
        lit("busy_ctl_kept", 1'b1, 8'h80);
        idle_cen(BC);
        lit("busy_clear", 1'b1, 8'h00);
        lit("busy_data_kept", 1'b0, 8'h3D);
        wr(8'h14);
        xfer(8'h80);
        wr(8'h5C);
        xfer(8'h80);
        bram_write(8'hA4, 8'h3C);
        wr(8'hBD);
        xfer(8'h80);
        wr(8'h14);
        xfer(8'h80);
        xfer(8'hC0);
        lit("bram_a5", 1'b0, 8'h5C);
        bram_read(8'hA4);
        lit("bram_a4", 1'b0, 8'h3C);

        // ctl_last during EXT returns to IDLE
        do_reset();
        wr(8'h3D);
        xfer(8'h80);
        wr(8'h18);
        xfer(8'hA0);
        wr(8'h01);
        xfer(8'h80);
        wr(8'h07);
        xfer(8'h80);
        read_secs(2'd0);
        lit("last_to_idle", 1'b0, 8'h07);

        // Seconds write coinciding with a tick keeps the tick
        do_reset();
        idle_cen(TPS - 4);
        wr(8'h01);
        xfer(8'h80);
        wr(8'h10);
        xfer(8'h80);
        read_secs(2'd0);
        lit("tick_deferred", 1'b0, 8'h11);

        // Reads change nothing; counter wraps from all ones
        do_reset();
        step(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
        lit("read_no_effect", 1'b1, 8'h00);
        write_secs(2'd3, 8'hFF);
        write_secs(2'd2, 8'hFF);
        write_secs(2'd1, 8'hFF);
        write_secs(2'd0, 8'hFF);
        idle_cen(TPS - 24);
        for (int b = 0; b < 4; b++) begin
            read_secs(2'(b));
            lit("wrap_byte", 1'b0, 8'h00);
        end

        // Reset during a pending BRAM write leaves the RAM untouched
        bram_select(8'hA5);
        wr(8'h99);
        step(1'b1, 1'b0, 1'b1, 8'h80, 1'b0);
        do_reset();
        bram_read(8'hA5);
        lit("abort_write", 1'b0, 8'h5C);

        do_reset();
        wr(8'h35);
        xfer(8'h80);
`ifdef RTC_BRAM_WRITE_PROTECT_EN
        wr(8'h80);
        xfer(8'h80);
        bram_write(8'h00, 8'hAA);
        bram_read(8'h00);
        lit("wp_dropped", 1'b0, 8'h00);
        wr(8'h35);
        xfer(8'h80);
        wr(8'h00);
        xfer(8'h80);
        bram_write(8'h00, 8'hAA);
        bram_read(8'h00);
        lit("wp_cleared", 1'b0, 8'hAA);
`else
        wr(8'h01);
        xfer(8'h80);
        wr(8'h20);
        xfer(8'h80);
        read_secs(2'd0);
        lit("cmd35_ignored", 1'b0, 8'h20);
`endif

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rtc_bram.md
RTC_BRAM -- requirements
Module: rtc_bram

Interface
REQ-001 Parameter TICKS_PER_SEC, default 2500000: cen pulses per seconds-counter increment, minimum 2.
REQ-002 Parameter BUSY_CEN, default 4: cen pulses the busy bit stays set after a start, minimum 1.
REQ-003 clk_sys  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cen  input  1  clock enable; the tick counter and busy counter advance only when cen=1.
REQ-006 strobe  input  1  one-clk_sys-cycle access request from the bus master.
REQ-007 rw  input  1  1=read access, 0=write access; sampled with strobe.
REQ-008 addr  input  1  0=data register ($C033), 1=control register ($C034).
REQ-009 din  input  8  write data; sampled with strobe.
REQ-010 dout  output  8  combinational: addr=0 gives the data register, addr=1 gives {busy, ctl_rd, ctl_last, 1'b0, ctl_low[3:0]}.

Function
REQ-011 The block SHALL hold a 32-bit seconds counter, a 256x8 battery RAM (BRAM), an 8-bit data register, control bits ctl_rd/ctl_last/ctl_low, a busy flag and an FSM with states IDLE, EXT and DATA.
REQ-012 A strobe with rw=1 SHALL change no state; dout is valid in the strobe cycle.
REQ-013 A write strobe to addr=0 SHALL load the data register, except that it SHALL be ignored while busy=1.
REQ-014 A write strobe to addr=1 while busy=0 SHALL store din[6] as ctl_rd, din[5] as ctl_last and din[3:0] as ctl_low; if din[7]=1 it SHALL also set busy and start one byte transfer.
REQ-015 A write strobe to addr=1 while busy=1 SHALL be ignored.
REQ-016 After a start, busy SHALL clear on the BUSY_CEN-th cen pulse; the transfer's effect SHALL be applied in the clk_sys cycle after the start strobe.
REQ-017 In IDLE, a transfer with ctl_rd=0 SHALL decode the data register as a command; a transfer with ctl_rd=1 SHALL load 0x00 into the data register and stay in IDLE.
REQ-018 Command z000ab01 (z=bit7) SHALL select seconds byte ab (0=LSB) and go to DATA.
REQ-019 Command z0111abc SHALL latch BRAM address bits [7:5]=abc and go to EXT.
REQ-020 In EXT, a transfer SHALL take data-register bits [6:2] as BRAM address bits [4:0] and go to DATA.
REQ-021 Any other command SHALL be ignored, and the FSM SHALL stay in IDLE.
REQ-022 In DATA, ctl_rd=1 SHALL load the selected byte into the data register, and ctl_rd=0 SHALL write the data register into the selected byte; the FSM SHALL then go to IDLE.
REQ-023 A transfer with ctl_last=1 SHALL return the FSM to IDLE after its own effect, in any state.
REQ-024 The seconds counter SHALL increment by 1 when the tick counter reaches TICKS_PER_SEC cen pulses, and SHALL wrap from 0xFFFFFFFF to 0x00000000.
REQ-025 A seconds-byte write coinciding with a tick SHALL apply the write first and then defer the increment by one clk_sys cycle, so no tick is lost.

Reset
REQ-026 Reset SHALL clear the seconds counter, tick counter, data register, control bits and busy, set the FSM to IDLE and clear the write-protect flag.
REQ-027 Reset SHALL leave the BRAM contents unchanged; simulation initial contents are 0x00.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no BRAM or seconds write.
REQ-029 After reset, dout SHALL read 0x00 for both addr values.

Configuration
REQ-030 Macro RTC_BRAM_WRITE_PROTECT_EN SHALL control the write-protect feature.
REQ-031 With the macro defined, command 0x35 SHALL go to DATA and its write SHALL store data-register bit7 as the write-protect flag.
REQ-032 With the macro defined and the write-protect flag set, all seconds and BRAM writes SHALL be dropped; command 0x35 SHALL still be accepted.
REQ-033 Without the macro, command 0x35 SHALL be handled as an unrecognised command, and no write-protect flag SHALL exist.

Verification
REQ-034 Reset, then read addr=1 -> dout=0x00; run 2*TICKS_PER_SEC cen pulses, read seconds byte 0 -> 0x02.
REQ-035 Write BRAM 0xA5=0x5C using extended command 0x3D, address byte 0x14 (bits[6:2]=0b00101), data 0x5C, then read it back with command 0xBD -> 0x5C; busy reads 1 for BUSY_CEN cen pulses after each start.
REQ-036 Write seconds bytes 3..0 = 0xFF, then let one tick elapse -> all four bytes read 0x00.
REQ-037 Write addr=0 (0x11) and addr=1 while busy=1 -> data register and FSM unchanged.
REQ-038 Send command 0x3D, then start a transfer with ctl_last=1 during EXT -> FSM returns to IDLE and the following byte 0x01 is decoded as seconds-byte-0 write.
REQ-039 With the macro defined, set write-protect (0x35, data 0x80), then write BRAM 0x00=0xAA -> readback 0x00; clear it and repeat -> readback 0xAA.
